// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the execute-stage data-memory port.
// It accepts one load or store at a time, waits WAIT cycles, performs the access
// on an internal word array, and returns read data plus an error flag.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   hs_ex4mem_val      request valid            (in)
//   hs_mem4ex_rdy      request ready            (out, registered)
//   i_mem_adr/i_mem_d  byte address / store data (in)
//   i_mem_ren/i_mem_wen load / store select      (in, exactly one must be set)
//   hs_mem2ex_val      response valid           (out, decoded from state)
//   hs_ex2mem_rdy      response accepted        (in)
//   o_mem_q            load data, 0 for stores and errors (out, registered)
//   o_mem_err          illegal request, no array side effect (out, registered)
module dmem_responder #(
    parameter int AW   = 10,
    parameter int WAIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hs_ex4mem_val,
    output logic        hs_mem4ex_rdy,
    input  logic [31:0] i_mem_adr,
    input  logic [31:0] i_mem_d,
    input  logic        i_mem_ren,
    input  logic        i_mem_wen,
    output logic        hs_mem2ex_val,
    input  logic        hs_ex2mem_rdy,
    output logic [31:0] o_mem_q,
    output logic        o_mem_err
);

    localparam int DEPTH = 1 << AW;
    localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] d;
        logic        ren;
        logic        wen;
    } mem_req_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic          rdy_q;
    logic          accept, resp_hs, enter_resp;
    mem_req_t      req_q, req_live, req_acc;
    logic          acc_err, acc_store;
    logic [AW-1:0] acc_idx;
    logic [31:0]   mem [DEPTH];

    assign hs_mem4ex_rdy = rdy_q;
    assign hs_mem2ex_val = (state == S_RESP);
    assign accept        = hs_ex4mem_val & rdy_q;
    assign resp_hs       = hs_mem2ex_val & hs_ex2mem_rdy;

    assign req_live = '{adr: i_mem_adr, d: i_mem_d, ren: i_mem_ren, wen: i_mem_wen};

    // With WAIT=0 the commit edge is the accept edge itself, so the access must
    // use the live inputs while in IDLE; otherwise it uses the latched copy.
    assign req_acc = (state == S_IDLE) ? req_live : req_q;
    assign acc_idx = req_acc.adr[AW+1:2];

    assign acc_err = (req_acc.ren == req_acc.wen)
                  || (req_acc.adr[1:0] != 2'b00)
                  || ((req_acc.adr >> (AW + 2)) != 32'd0);
    assign acc_store = req_acc.wen & ~acc_err;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT == 0) begin
                        state_nxt  = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt  = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_hs) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            rdy_q     <= 1'b0;
            req_q     <= '0;
            o_mem_q   <= 32'd0;
            o_mem_err <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // Registered ready: held low through reset, and only high in IDLE.
            rdy_q <= (state_nxt == S_IDLE);
            if (accept) req_q <= req_live;
            if (enter_resp) begin
                o_mem_err <= acc_err;
                o_mem_q   <= (acc_err || !req_acc.ren) ? 32'd0 : mem[acc_idx];
            end else if (resp_hs) begin
                o_mem_err <= 1'b0;
                o_mem_q   <= 32'd0;
            end
        end
    end

    // Array is not reset; writes only on the commit edge of a legal store.
    always_ff @(posedge clk) begin
        if (enter_resp && acc_store) mem[acc_idx] <= req_acc.d;
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NDUT-1:0] ex_val, rdy, ren, wen, rsp_val, rsp_rdy, err;
    logic [31:0] adr [NDUT];
    logic [31:0] dd  [NDUT];
    logic [31:0] q   [NDUT];

    // Reference memory per instance, word-indexed.
    logic [31:0] mdl [NDUT][1024];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 5);
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dmem_responder #(.AW(10), .WAIT((g == 0) ? 0 : ((g == 1) ? 3 : 5))) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .hs_ex4mem_val (ex_val[g]),
            .hs_mem4ex_rdy (rdy[g]),
            .i_mem_adr     (adr[g]),
            .i_mem_d       (dd[g]),
            .i_mem_ren     (ren[g]),
            .i_mem_wen     (wen[g]),
            .hs_mem2ex_val (rsp_val[g]),
            .hs_ex2mem_rdy (rsp_rdy[g]),
            .o_mem_q       (q[g]),
            .o_mem_err     (err[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Caller sits at a negedge.
    task automatic wait_rdy(input int k);
        int n = 0;
        while (!rdy[k] && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[k]) chk("rdy_timeout", 32'(rdy[k]), 32'd1);
    endtask

    // One full transaction: issue, measure latency, optional backpressure,
    // handshake, compare against the reference rules, update the model.
    task automatic do_req(input int k, input logic [31:0] a, input logic [31:0] d,
                          input bit r, input bit w, input int bp, input bit chg);
        int lat;
        bit rdy_seen;
        logic [31:0] q0, e_q;
        logic e_err;
        int idx;
        e_err = (r == w) || (a[1:0] != 2'b00) || (a >= 32'h1000);
        idx   = int'(a[11:2]);
        e_q   = (e_err || !r) ? 32'd0 : mdl[k][idx];
        wait_rdy(k);
        ex_val[k] = 1'b1; adr[k] = a; dd[k] = d; ren[k] = r; wen[k] = w;
        @(posedge clk);
        lat = 0;
        rdy_seen = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                ex_val[k] = 1'b0;
                if (chg) begin
                    adr[k] = a ^ 32'h0000_0ff0;
                    dd[k]  = ~d;
                end
            end
            if (rdy[k]) rdy_seen = 1;
        end while (!rsp_val[k] && lat < 40);
        chk($sformatf("lat%0d", k), 32'(lat), 32'(wait_of(k) + 1));
        chk("rdy_busy", 32'(rdy_seen), 32'd0);
        chk($sformatf("q%0d@%0h", k, a), q[k], e_q);
        chk($sformatf("err%0d@%0h", k, a), 32'(err[k]), 32'(e_err));
        q0 = q[k];
        if (bp > 0) begin
            // A competing request during backpressure must not be taken.
            ex_val[k] = 1'b1; adr[k] = 32'h104; dd[k] = 32'h5a5a5a5a; ren[k] = 0; wen[k] = 1;
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                chk("bp_val", 32'(rsp_val[k]), 32'd1);
                chk("bp_q", q[k], q0);
                chk("bp_rdy", 32'(rdy[k]), 32'd0);
            end
            ex_val[k] = 1'b0;
        end
        rsp_rdy[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_rdy[k] = 1'b0;
        chk("post_val", 32'(rsp_val[k]), 32'd0);
        chk("post_rdy", 32'(rdy[k]), 32'd1);
        if (!e_err && w) mdl[k][idx] = d;
    endtask

    task automatic rand_op(input int k);
        int sel;
        logic [31:0] a;
        bit r, w;
        sel = $urandom_range(0, 9);
        a = 32'h100 + 32'(4 * $urandom_range(0, 15));
        r = $urandom_range(0, 1);
        w = !r;
        case (sel)
            0: a = a + 32'($urandom_range(1, 3));
            1: a = 32'h1000 + 32'(4 * $urandom_range(0, 1000));
            2: begin r = $urandom_range(0, 1); w = r; end
            default: ;
        endcase
        do_req(k, a, $urandom, r, w, $urandom_range(0, 2), bit'($urandom_range(0, 1)));
    endtask

    initial begin
        ex_val = '0; ren = '0; wen = '0; rsp_rdy = '0;
        for (int k = 0; k < NDUT; k++) begin
            adr[k] = 32'd0;
            dd[k]  = 32'd0;
        end
        #12;
        for (int k = 0; k < NDUT; k++) begin
            chk("rst_rdy", 32'(rdy[k]), 32'd0);
            chk("rst_val", 32'(rsp_val[k]), 32'd0);
            chk("rst_q", q[k], 32'd0);
            chk("rst_err", 32'(err[k]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) chk("rdy_after_rst", 32'(rdy[k]), 32'd1);

        // Basic store/load, WAIT=0 and WAIT=3.
        do_req(0, 32'h10, 32'hDEADBEEF, 0, 1, 0, 0);
        do_req(0, 32'h10, 32'h0, 1, 0, 0, 0);
        do_req(1, 32'h40, 32'h12345678, 0, 1, 0, 0);
        do_req(1, 32'h40, 32'h0, 1, 0, 0, 0);
        // Backpressure on a load response.
        do_req(0, 32'h10, 32'h0, 1, 0, 5, 0);
        // Errors.
        do_req(0, 32'h02, 32'h0, 1, 0, 0, 0);
        do_req(0, 32'h1000, 32'h0, 1, 0, 0, 0);
        do_req(0, 32'h20, 32'h0BADF00D, 0, 1, 0, 0);
        do_req(0, 32'h20, 32'hFFFFFFFF, 1, 1, 0, 0);
        do_req(0, 32'h20, 32'hFFFFFFFF, 0, 0, 0, 0);
        do_req(0, 32'h20, 32'h0, 1, 0, 0, 0);
        do_req(1, 32'h22, 32'h77, 0, 1, 1, 0);

        // Reset during WAIT aborts a pending store.
        do_req(2, 32'h8, 32'h11111111, 0, 1, 0, 0);
        wait_rdy(2);
        ex_val[2] = 1'b1; adr[2] = 32'h8; dd[2] = 32'hAAAA5555; ren[2] = 0; wen[2] = 1;
        @(posedge clk);
        @(negedge clk);
        ex_val[2] = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_val", 32'(rsp_val[2]), 32'd0);
        chk("mid_rst_rdy", 32'(rdy[2]), 32'd0);
        chk("mid_rst_q", q[2], 32'd0);
        chk("mid_rst_err", 32'(err[2]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_req(2, 32'h8, 32'h0, 1, 0, 0, 0);

        // Inputs change right after accept; latched values must be used.
        do_req(0, 32'h30, 32'hCAFE0001, 0, 1, 0, 1);
        do_req(0, 32'h30, 32'h0, 1, 0, 0, 1);
        do_req(2, 32'h34, 32'hCAFE0002, 0, 1, 0, 1);
        do_req(2, 32'h34, 32'h0, 1, 0, 1, 1);

        // Randomized traffic over a preloaded pool.
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 16; i++)
                do_req(k, 32'h100 + 32'(4 * i), $urandom, 0, 1, 0, 0);
            for (int i = 0; i < 30; i++) rand_op(k);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout got=%0d exp=%0d", n_chk, 0);
        $fatal(1);
    end

endmodule
